capture_sequencer: RTL and testbench

Sequences sample capture into the single-port sample RAM and arbitrates that RAM between the capture write path and a readout requester. Sits in the `clk` domain between the SIPO/controller pair and the sample RAM. Consumes one `sample_valid` pulse per converted word, fills the RAM from address 0 after an arm, and raises `done` when the buffer is full. A requester, such as the display or a later host link, reads any word back through a req/valid handshake.

---
 rtl/capture_pkg.sv | 7 +
 rtl/ram_port_arbiter.sv | 49 ++++
 rtl/capture_sequencer.sv | 86 ++++++++
 tb/tb_capture_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// capture_pkg: shared state type and default sizes for the capture sequencer.
package capture_pkg;
    typedef enum logic [1:0] {IDLE, FILL, FULL} cap_state_t;
    localparam int CAP_WORD_SIZE = 10;
    localparam int CAP_ADDR_W    = 4;
    localparam int RD_LAT        = 3;
endpackage

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: grants the single RAM port to a capture write or a pending read,
// and carries one outstanding read through address and data capture stages.
module ram_port_arbiter import capture_pkg::*; #(
    parameter int WORD_SIZE = CAP_WORD_SIZE,
    parameter int ADDR_W    = CAP_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic                 rd_req,
    input  logic [ADDR_W-1:0]    rd_addr,
    input  logic [WORD_SIZE-1:0] ram_rdata,
    output logic                 ram_we,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [WORD_SIZE-1:0] ram_wdata,
    output logic                 rd_valid,
    output logic [WORD_SIZE-1:0] rd_data
);
    logic [RD_LAT-2:0] rd_pipe;
    logic              rd_grant;

    // rd_valid is part of the outstanding window so rd_req is not re-sampled alongside it
    assign rd_grant = rd_req && !wr_en && !(|rd_pipe) && !rd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            rd_pipe   <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            ram_we <= wr_en;
            if (wr_en) begin
                ram_addr  <= wr_addr;
                ram_wdata <= wr_data;
            end else if (rd_grant) begin
                ram_addr <= rd_addr;
            end
            rd_pipe  <= {rd_pipe[RD_LAT-3:0], rd_grant};
            rd_valid <= rd_pipe[RD_LAT-2];
            if (rd_pipe[RD_LAT-2])
                rd_data <= ram_rdata;
        end
    end
endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer: fills the sample RAM from address 0 after arm and arbitrates readout.
// Optional CAPTURE_OVERRUN_CNT_EN adds a saturating count of samples dropped while FULL.
module capture_sequencer import capture_pkg::*; #(
    parameter int WORD_SIZE = CAP_WORD_SIZE,
    parameter int ADDR_W    = CAP_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arm,
    input  logic                 sample_valid,
    input  logic [WORD_SIZE-1:0] sample_data,
    input  logic                 rd_req,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic                 rd_valid,
    output logic [WORD_SIZE-1:0] rd_data,
    output logic                 ram_we,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [WORD_SIZE-1:0] ram_wdata,
    input  logic [WORD_SIZE-1:0] ram_rdata,
    output logic                 busy,
    output logic                 done,
`ifdef CAPTURE_OVERRUN_CNT_EN
    output logic [7:0]           overrun_cnt,
`endif
    output logic [ADDR_W:0]      fill_count
);
    localparam int DEPTH = 2**ADDR_W;

    cap_state_t          state, state_d;
    logic [ADDR_W:0]     fill_d;
    logic                wr_en;

    assign wr_en = (state == FILL) && sample_valid && !arm;
    assign busy  = (state == FILL);
    assign done  = (state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fill_count <= '0;
        end else begin
            state      <= state_d;
            fill_count <= fill_d;
        end
    end

    always_comb begin
        state_d = state;
        fill_d  = fill_count;
        if (arm) begin
            state_d = FILL;
            fill_d  = '0;
        end else if (wr_en) begin
            fill_d = fill_count + 1'b1;
            if (fill_count == (ADDR_W+1)'(DEPTH-1))
                state_d = FULL;
        end
    end

`ifdef CAPTURE_OVERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overrun_cnt <= '0;
        else if (arm)
            overrun_cnt <= '0;
        else if (state == FULL && sample_valid && overrun_cnt != 8'hff)
            overrun_cnt <= overrun_cnt + 8'd1;
    end
`endif

    ram_port_arbiter #(.WORD_SIZE(WORD_SIZE), .ADDR_W(ADDR_W)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (fill_count[ADDR_W-1:0]),
        .wr_data   (sample_data),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .ram_rdata (ram_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data)
    );
endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: directed plus random stimulus against a behavioural capture/readout model.
module tb_capture_sequencer;
    localparam int WS = 10, AW = 4, DEPTH = 16;

    logic clk = 1'b0, rst_n = 1'b0, arm = 1'b0, sample_valid = 1'b0, rd_req = 1'b0;
    logic [WS-1:0] sample_data = '0;
    logic [AW-1:0] rd_addr = '0;
    logic rd_valid, ram_we, busy, done;
    logic [WS-1:0] rd_data, ram_wdata;
    logic [WS-1:0] ram_rdata = '0;
    logic [AW-1:0] ram_addr;
    logic [AW:0] fill_count;
`ifdef CAPTURE_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt;
`endif

    capture_sequencer dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .sample_valid(sample_valid),
        .sample_data(sample_data), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy), .done(done),
`ifdef CAPTURE_OVERRUN_CNT_EN
        .overrun_cnt(overrun_cnt),
`endif
        .fill_count(fill_count)
    );

    always #5 clk = ~clk;

    logic [WS-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    int total = 0, bad = 0;
    int m_state = 0, m_cnt = 0, m_ovr = 0, edge_n = 0, m_rd_edge = 0, rd_wait = 0;
    bit m_we = 0, m_rd_busy = 0;
    logic [AW-1:0] m_waddr = '0, m_raddr = '0;
    logic [WS-1:0] m_wdata = '0, m_rexp = '0, m_rd_data = '0;
    logic [WS-1:0] m_mem [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        int old_state = m_state;
        edge_n++;
        m_we = (m_state == 1) && sample_valid && !arm;
        if (rd_req && !m_we && !m_rd_busy) begin
            m_rd_busy = 1; m_rd_edge = edge_n; m_raddr = rd_addr; m_rexp = m_mem[rd_addr];
        end else if (m_rd_busy && edge_n == m_rd_edge + 3) begin
            m_rd_busy = 0;
        end
        if (m_we) begin
            m_waddr = AW'(m_cnt); m_wdata = sample_data; m_mem[m_cnt] = sample_data;
            m_cnt++;
            if (m_cnt == DEPTH) m_state = 2;
        end
        if (arm) begin
            m_state = 1; m_cnt = 0; m_ovr = 0;
        end else if (old_state == 2 && sample_valid && m_ovr < 255) begin
            m_ovr++;
        end
    endtask

    task automatic check_outputs();
        bit exp_rv = m_rd_busy && edge_n == m_rd_edge + 2;
        check("ram_we", ram_we, m_we);
        if (m_we) begin
            check("wr_addr", ram_addr, m_waddr);
            check("wr_data", ram_wdata, m_wdata);
        end
        if (m_rd_busy && edge_n == m_rd_edge) check("rd_ram_addr", ram_addr, m_raddr);
        check("rd_valid", rd_valid, exp_rv);
        if (exp_rv) m_rd_data = m_rexp;
        check("rd_data", rd_data, m_rd_data);
        check("busy", busy, m_state == 1);
        check("done", done, m_state == 2);
        check("fill_count", fill_count, m_cnt);
`ifdef CAPTURE_OVERRUN_CNT_EN
        check("overrun_cnt", overrun_cnt, m_ovr);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
        if (rd_req) begin
            rd_wait++;
            if (rd_valid) rd_req = 1'b0;
            else if (rd_wait > 8) begin
                check("rd_timeout_valid", rd_valid, 1'b1);
                rd_req = 1'b0;
            end
        end
    endtask

    task automatic cyc(input bit a, input bit s, input logic [WS-1:0] d);
        arm = a; sample_valid = s; sample_data = d;
        tick();
        arm = 1'b0; sample_valid = 1'b0;
    endtask

    task automatic start_read(input logic [AW-1:0] a);
        rd_req = 1'b1; rd_addr = a; rd_wait = 0;
    endtask

    task automatic wait_read();
        for (int i = 0; i < 12 && rd_req; i++) cyc(0, 0, '0);
        repeat (2) cyc(0, 0, '0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ram_we"}, ram_we, 1'b0);
        check({tag, "_ram_addr"}, ram_addr, '0);
        check({tag, "_ram_wdata"}, ram_wdata, '0);
        check({tag, "_rd_valid"}, rd_valid, 1'b0);
        check({tag, "_rd_data"}, rd_data, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_fill"}, fill_count, '0);
`ifdef CAPTURE_OVERRUN_CNT_EN
        check({tag, "_ovr"}, overrun_cnt, '0);
`endif
    endtask

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, WS'(base + i));
            cyc(0, 0, '0);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = WS'(i * 37 + 100);
            m_mem[i] = WS'(i * 37 + 100);
        end
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        cyc(0, 1, 10'h2aa);
        cyc(0, 0, '0);
        // full capture of 0..15
        cyc(1, 0, '0);
        fill(16, 0);
        check("done16", done, 1'b1);
        check("fill16", fill_count, 5'd16);
        cyc(0, 1, 10'h111);
        cyc(0, 0, '0);
        start_read(4'd5);
        wait_read();
        check("rd5", rd_data, 10'd5);
        // write and read collide in FILL
        cyc(1, 0, '0);
        fill(3, 100);
        start_read(4'd1);
        cyc(0, 1, 10'h1ee);
        wait_read();
        check("rd_collide", rd_data, 10'd101);
        // arm with a simultaneous sample at fill_count=7
        cyc(1, 0, '0);
        fill(7, 200);
        cyc(1, 1, 10'h3ff);
        check("rearm_fill", fill_count, '0);
        cyc(0, 0, '0);
        cyc(0, 1, 10'h155);
        check("rearm_addr", ram_addr, '0);
        cyc(0, 0, '0);
        // reset between grant and rd_valid
        start_read(4'd2);
        tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("midread");
        @(negedge clk);
        rst_n = 1'b1; rd_req = 1'b0;
        m_state = 0; m_cnt = 0; m_ovr = 0; m_rd_busy = 0; m_rd_data = '0; m_we = 0;
        for (int i = 0; i < 5; i++) cyc(0, 0, '0);
        cyc(0, 1, 10'h0f0);
        cyc(0, 0, '0);
`ifdef CAPTURE_OVERRUN_CNT_EN
        cyc(1, 0, '0);
        fill(16, 50);
        fill(300, 0);
        check("ovr_sat", overrun_cnt, 8'd255);
        cyc(1, 0, '0);
        check("ovr_clr", overrun_cnt, 8'd0);
`endif
        // random traffic
        begin
            bit prev_sv = 0;
            for (int i = 0; i < 1500; i++) begin
                bit a = ($urandom_range(0, 59) == 0);
                bit s = !prev_sv && ($urandom_range(0, 1) == 1);
                if (!rd_req && $urandom_range(0, 3) == 0) start_read(AW'($urandom_range(0, DEPTH - 1)));
                cyc(a, s, WS'($urandom));
                prev_sv = s;
            end
        end
        rd_req = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
